// File: rtl/mo_line_buffer_pp.sv
// -----------------------------------------------------------------------------
// mo_line_buffer_pp
//   Ping-pong motion-object line buffer. The MO pixel serialiser writes one
//   scanline into the write bank. At the same time the video path reads the
//   other bank and clears each location as it reads it, so that bank comes
//   back clean for reuse after the next swap.
//   After reset, a clear sweep fills both banks with CLEAR (all ones) before
//   the block accepts any traffic.
//
// Ports
//   i_clk        pixel clock; all logic runs on posedge
//   i_reset      synchronous, active-low
//   i_swap       line-boundary pulse; exchanges the write and read banks
//   i_hflip      1 = write pointer decrements after each write
//   i_wr_load    load the write pointer from i_wr_x
//   i_wr_x       start X of the next object strip
//   i_wr_valid   i_wr_pix is present; it is written at the pointer, then the
//                pointer steps
//   i_wr_pix     object pixel {prio, ..., colour}
//   i_rd_en      advance the display read by one pixel
//   o_rd_pix     display pixel (registered, 1-cycle latency)
//   o_rd_valid   o_rd_pix answers an i_rd_en of the previous cycle
//   o_wr_bank    bank being written (read bank = ~o_wr_bank)
//   o_coll       sticky: an opaque pixel was written over an opaque pixel
//                during this line
//   o_init_done  clear sweep is complete
// -----------------------------------------------------------------------------
module mo_line_buffer_pp #(
  parameter int PIX_W     = 8,
  parameter int COLOR_W   = 4,
  parameter int PRIO_W    = 2,
  parameter int ADDR_W    = 9,
  parameter int LINE_LEN  = 336,
  parameter int PRIO_MODE = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_swap,
  input  logic              i_hflip,
  input  logic              i_wr_load,
  input  logic [ADDR_W-1:0] i_wr_x,
  input  logic              i_wr_valid,
  input  logic [PIX_W-1:0]  i_wr_pix,
  input  logic              i_rd_en,
  output logic [PIX_W-1:0]  o_rd_pix,
  output logic              o_rd_valid,
  output logic              o_wr_bank,
  output logic              o_coll,
  output logic              o_init_done
);

  localparam logic [PIX_W-1:0]   LP_CLEAR  = {PIX_W{1'b1}};
  localparam logic [COLOR_W-1:0] LP_TRANSP = {COLOR_W{1'b1}};
  localparam logic [ADDR_W:0]    LP_LEN    = (ADDR_W+1)'(LINE_LEN);
  localparam logic [ADDR_W-1:0]  LP_LAST   = ADDR_W'(LINE_LEN - 1);
  localparam bit                 LP_PRIO_EN = (PRIO_MODE != 0);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_init_addr;
  logic               r_init_done;
  logic               r_wr_bank;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W:0]    r_rd_ptr;      // one extra bit so it can rest at LINE_LEN
  logic [PIX_W-1:0]   r_rd_pix;
  logic               r_rd_valid;
  logic               r_coll;

  // Write pipeline stage 2: the stored value was read in stage 1 and the
  // compare-and-write happens here.
  logic               r_s2_valid;
  logic               r_s2_bank;
  logic [ADDR_W-1:0]  r_s2_addr;
  logic [PIX_W-1:0]   r_s2_pix;
  logic [PIX_W-1:0]   r_s2_old;

  logic [PIX_W-1:0]   r_mem [2][LINE_LEN];

  logic               w_run;
  logic [ADDR_W-1:0]  w_wr_target;
  logic [ADDR_W-1:0]  w_wr_ptr_next;
  logic               w_wr_opaque;
  logic               w_wr_in_range;
  logic               w_s1_fire;
  logic [PIX_W-1:0]   w_s1_old;
  logic               w_s2_old_opaque;
  logic               w_s2_prio_ok;
  logic               w_s2_write;
  logic               w_rd_bank;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic               w_rd_in_range;
  logic               w_rd_fire;
  logic [PIX_W-1:0]   w_rd_data;

  assign w_run         = (r_state == ST_RUN);
  assign w_wr_target   = i_wr_load ? i_wr_x : r_wr_ptr;
  assign w_wr_ptr_next = i_hflip ? (w_wr_target - ADDR_W'(1))
                                 : (w_wr_target + ADDR_W'(1));
  assign w_wr_opaque   = (i_wr_pix[COLOR_W-1:0] != LP_TRANSP);
  assign w_wr_in_range = ({1'b0, w_wr_target} < LP_LEN);
  assign w_s1_fire     = w_run & i_wr_valid & w_wr_opaque & w_wr_in_range;

  assign w_s2_old_opaque = (r_s2_old[COLOR_W-1:0] != LP_TRANSP);
  assign w_s2_prio_ok    = (r_s2_pix[PIX_W-1 -: PRIO_W] >= r_s2_old[PIX_W-1 -: PRIO_W]);
  // A losing-priority write is suppressed; the collision is still flagged.
  assign w_s2_write      = r_s2_valid & (!LP_PRIO_EN | ~w_s2_old_opaque | w_s2_prio_ok);

  assign w_rd_bank     = ~r_wr_bank;
  assign w_rd_addr     = r_rd_ptr[ADDR_W-1:0];
  assign w_rd_in_range = (r_rd_ptr < LP_LEN);
  assign w_rd_fire     = w_run & i_rd_en & w_rd_in_range;

  // Stage-1 read and display read. Both forward the stage-2 write that is
  // about to land, so neither sees a stale location. The display-side
  // forward only matters right after a swap, when the pending write targets
  // what has just become the read bank.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_s1_old  = r_mem[r_wr_bank][w_wr_target];
    w_rd_data = r_mem[w_rd_bank][w_rd_addr];
    if (w_s2_write && (r_s2_bank == r_wr_bank) && (r_s2_addr == w_wr_target)) begin
      w_s1_old = r_s2_pix;
    end
    if (w_s2_write && (r_s2_bank == w_rd_bank) && (r_s2_addr == w_rd_addr)) begin
      w_rd_data = r_s2_pix;
    end
  end

  // Storage. The clear-on-read is issued after the object write, so the
  // clear takes precedence if both hit one location in the same cycle.
  // NOTE: the memory array is not reset. The post-reset sweep initialises
  // it, which keeps it mappable to RAM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      if (!w_run) begin
        r_mem[0][r_init_addr] <= LP_CLEAR;
        r_mem[1][r_init_addr] <= LP_CLEAR;
      end else begin
        if (w_s2_write) begin
          r_mem[r_s2_bank][r_s2_addr] <= r_s2_pix;
        end
        if (w_rd_fire) begin
          r_mem[w_rd_bank][w_rd_addr] <= LP_CLEAR;
        end
      end
    end
  end

  // Control FSM with registered outputs.
  // NOTE: sequential state is assigned only with <=, so every register here
  // samples values from before the clock edge, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
      r_wr_bank   <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_pix    <= LP_CLEAR;
      r_rd_valid  <= 1'b0;
      r_coll      <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_bank   <= 1'b0;
      r_s2_addr   <= '0;
      r_s2_pix    <= '0;
      r_s2_old    <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_rd_valid  <= 1'b0;
          r_s2_valid  <= 1'b0;
          r_init_addr <= r_init_addr + ADDR_W'(1);
          if (r_init_addr == LP_LAST) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end

        ST_RUN: begin
          // Write pointer: transparent and clipped pixels still step it.
          if (i_wr_valid) begin
            r_wr_ptr <= w_wr_ptr_next;
          end else if (i_wr_load) begin
            r_wr_ptr <= i_wr_x;
          end

          r_s2_valid <= w_s1_fire;
          r_s2_bank  <= r_wr_bank;
          r_s2_addr  <= w_wr_target;
          r_s2_pix   <= i_wr_pix;
          r_s2_old   <= w_s1_old;

          // A collision detected on the swap edge belongs to the line that
          // is ending and is discarded.
          if (i_swap) begin
            r_coll <= 1'b0;
          end else if (r_s2_valid && w_s2_old_opaque) begin
            r_coll <= 1'b1;
          end

          if (i_rd_en) begin
            r_rd_valid <= 1'b1;
            if (w_rd_in_range) begin
              r_rd_pix <= w_rd_data;
              r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
            end else begin
              r_rd_pix <= LP_CLEAR;
            end
          end else begin
            r_rd_valid <= 1'b0;
          end

          // Swap overrides the read-pointer step above.
          if (i_swap) begin
            r_wr_bank <= ~r_wr_bank;
            r_rd_ptr  <= '0;
          end
        end

        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign o_rd_pix    = r_rd_pix;
  assign o_rd_valid  = r_rd_valid;
  assign o_wr_bank   = r_wr_bank;
  assign o_coll      = r_coll;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_mo_line_buffer_pp.sv
// -----------------------------------------------------------------------------
// tb_mo_line_buffer_pp
//   Drives two copies of mo_line_buffer_pp with identical stimulus: one with
//   PRIO_MODE=0 and one with PRIO_MODE=1. A transaction-level model keeps one
//   line image per bank per copy and applies each cycle's write, read and
//   swap directly. Outputs are compared 1 time unit after every rising edge.
// -----------------------------------------------------------------------------
module tb_mo_line_buffer_pp;

  localparam int PIX_W    = 8;
  localparam int ADDR_W   = 9;
  localparam int LINE_LEN = 336;
  localparam int ADDR_MOD = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset, swap, hflip, wr_load, wr_valid, rd_en;
  logic [ADDR_W-1:0] wr_x;
  logic [PIX_W-1:0]  wr_pix;

  logic [PIX_W-1:0]  rd_pix0, rd_pix1;
  logic              rd_valid0, rd_valid1, wr_bank0, wr_bank1;
  logic              coll0, coll1, init_done0, init_done1;

  always #5 clk = ~clk;

  mo_line_buffer_pp #(.PRIO_MODE(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_swap(swap), .i_hflip(hflip),
    .i_wr_load(wr_load), .i_wr_x(wr_x), .i_wr_valid(wr_valid), .i_wr_pix(wr_pix),
    .i_rd_en(rd_en), .o_rd_pix(rd_pix0), .o_rd_valid(rd_valid0),
    .o_wr_bank(wr_bank0), .o_coll(coll0), .o_init_done(init_done0)
  );

  mo_line_buffer_pp #(.PRIO_MODE(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_swap(swap), .i_hflip(hflip),
    .i_wr_load(wr_load), .i_wr_x(wr_x), .i_wr_valid(wr_valid), .i_wr_pix(wr_pix),
    .i_rd_en(rd_en), .o_rd_pix(rd_pix1), .o_rd_valid(rd_valid1),
    .o_wr_bank(wr_bank1), .o_coll(coll1), .o_init_done(init_done1)
  );

  // ---------------- reference model ----------------
  // m_mem[copy][bank][x] ; copy 0 = last opaque wins, copy 1 = priority gated
  logic [7:0] m_mem [2][2][LINE_LEN];
  bit         m_ready;
  int         m_cnt;
  bit         m_bank;
  int         m_wr_ptr;
  int         m_rd_ptr;
  bit         m_coll [2];
  logic [7:0] m_rd_pix [2];
  bit         m_rd_valid;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int d, input int t, input logic [7:0] px);
    logic [7:0] old;
    if (px[3:0] == 4'hF || t >= LINE_LEN) return;
    old = m_mem[d][m_bank][t];
    if (old[3:0] != 4'hF) m_coll[d] = 1'b1;
    if (d == 0 || old[3:0] == 4'hF || px[7:6] >= old[7:6])
      m_mem[d][m_bank][t] = px;
  endtask

  task automatic model_edge(input bit rst, input bit sw, input bit hf, input bit ld,
                            input int x, input bit wv, input logic [7:0] px, input bit re);
    int t;
    if (!rst) begin
      m_ready = 0; m_cnt = 0; m_bank = 0; m_wr_ptr = 0; m_rd_ptr = 0;
      m_rd_valid = 0;
      for (int d = 0; d < 2; d++) begin
        m_rd_pix[d] = 8'hFF;
        m_coll[d]   = 0;
      end
      return;
    end
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == LINE_LEN) begin
        m_ready = 1;
        for (int d = 0; d < 2; d++)
          for (int b = 0; b < 2; b++)
            for (int a = 0; a < LINE_LEN; a++) m_mem[d][b][a] = 8'hFF;
      end
      return;
    end
    if (wv) begin
      t = ld ? x : m_wr_ptr;
      for (int d = 0; d < 2; d++) model_write(d, t, px);
      m_wr_ptr = (hf ? t - 1 : t + 1 + ADDR_MOD) % ADDR_MOD;
      if (m_wr_ptr < 0) m_wr_ptr += ADDR_MOD;
    end else if (ld) begin
      m_wr_ptr = x;
    end
    if (re) begin
      m_rd_valid = 1;
      for (int d = 0; d < 2; d++) begin
        if (m_rd_ptr < LINE_LEN) begin
          m_rd_pix[d] = m_mem[d][!m_bank][m_rd_ptr];
          m_mem[d][!m_bank][m_rd_ptr] = 8'hFF;
        end else begin
          m_rd_pix[d] = 8'hFF;
        end
      end
      if (m_rd_ptr < LINE_LEN) m_rd_ptr++;
    end else begin
      m_rd_valid = 0;
    end
    if (sw) begin
      m_bank   = !m_bank;
      m_rd_ptr = 0;
      for (int d = 0; d < 2; d++) m_coll[d] = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit rst, input bit sw, input bit hf, input bit ld,
                      input int x, input bit wv, input logic [7:0] px, input bit re);
    logic [31:0] xv;
    xv       = x;
    reset    = rst;
    swap     = sw;
    hflip    = hf;
    wr_load  = ld;
    wr_x     = xv[ADDR_W-1:0];
    wr_valid = wv;
    wr_pix   = px;
    rd_en    = re;
    model_edge(rst, sw, hf, ld, x, wv, px, re);
    @(posedge clk);
    #1;
    check("rd_valid0",  rd_valid0,  m_rd_valid);
    check("rd_valid1",  rd_valid1,  m_rd_valid);
    check("rd_pix0",    rd_pix0,    m_rd_pix[0]);
    check("rd_pix1",    rd_pix1,    m_rd_pix[1]);
    check("wr_bank0",   wr_bank0,   m_bank);
    check("wr_bank1",   wr_bank1,   m_bank);
    check("init_done0", init_done0, m_ready);
    check("init_done1", init_done1, m_ready);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic wr(input bit ld, input int x, input bit hf, input logic [7:0] px);
    step(1, 0, hf, ld, x, 1, px, 0);
  endtask

  task automatic do_swap();
    step(1, 1, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 8'h00, 1);
  endtask

  // coll lags the write by one cycle, so call this after an idle step
  task automatic check_coll(input string tag);
    check({tag, "_coll0"}, coll0, m_coll[0]);
    check({tag, "_coll1"}, coll1, m_coll[1]);
  endtask

  initial begin
    // reset, clear sweep, full read of the fresh read bank
    step(0, 0, 0, 0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 0, 0, 0, 8'h00, 1);
    check_coll("reset");
    idle(LINE_LEN + 2);
    read_n(LINE_LEN + 4);

    // basic strip, swap, read, then reread after the next swap
    wr(1, 10, 0, 8'h21);
    wr(0, 0, 0, 8'h22);
    wr(0, 0, 0, 8'h23);
    idle(1);
    do_swap();
    read_n(16);
    do_swap();
    read_n(LINE_LEN + 1);
    do_swap();
    read_n(LINE_LEN + 1);

    // hflip across the left edge, then step forward from the wrapped pointer
    wr(1, 2, 1, 8'h31);
    wr(0, 0, 1, 8'h32);
    wr(0, 0, 1, 8'h33);
    wr(0, 0, 1, 8'h34);
    wr(0, 0, 0, 8'h35);
    wr(0, 0, 0, 8'h36);
    wr(0, 0, 0, 8'h37);
    idle(1);
    check_coll("hflip_wrap");
    // right-edge clip
    wr(1, LINE_LEN - 1, 0, 8'h41);
    wr(0, 0, 0, 8'h42);
    wr(0, 0, 0, 8'h43);
    wr(0, 0, 0, 8'h44);
    idle(1);
    do_swap();
    idle(1);
    check_coll("swap_clear0");
    read_n(LINE_LEN + 1);

    // priority: 85 then 41 at x=20 and x=21, then C3 at x=20
    wr(1, 20, 0, 8'h85);
    idle(1);
    wr(1, 20, 0, 8'h41);
    idle(1);
    check_coll("prio_loss");
    wr(1, 21, 0, 8'h85);
    wr(1, 21, 0, 8'h41);
    wr(1, 20, 0, 8'hC3);
    idle(1);
    do_swap();
    idle(1);
    check_coll("swap_clear1");
    read_n(24);

    // back-to-back writes to the same address exercise forwarding
    do_swap();
    wr(1, 5, 0, 8'h11);
    wr(1, 5, 0, 8'h12);
    idle(1);
    check_coll("fwd");
    do_swap();
    read_n(8);

    // randomized lines
    for (int line = 0; line < 8; line++) begin
      for (int c = 0; c < 400; c++) begin
        logic [7:0] px;
        px = 8'($urandom);
        if ($urandom_range(0, 3) == 0) px[3:0] = 4'hF;
        step(1, 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
             $urandom_range(0, ADDR_MOD - 1), ($urandom_range(0, 1) == 1), px,
             ($urandom_range(0, 3) != 0));
      end
      idle(1);
      check_coll("rand");
      step(1, 1, 0, 0, 0, 0, 8'h00, ($urandom_range(0, 1) == 1));
    end

    // reset in the middle of a line read
    read_n(50);
    step(0, 0, 0, 0, 0, 0, 8'h00, 1);
    check_coll("mid_reset");
    idle(LINE_LEN + 1);
    read_n(LINE_LEN + 1);
    do_swap();
    read_n(LINE_LEN + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
